rename_table: RTL and testbench



---
 rtl/mips_core_pkg.sv | 7 +
 rtl/rename_free_list.sv | 58 +++++
 rtl/rename_table.sv | 137 +++++++++++++
 tb/tb_rename_table.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types and sizing for the rename stage and its neighbours.
package mips_core_pkg;
   localparam int PHYS_REG_COUNT = 64;
   localparam int CKPT_COUNT     = 4;
   localparam int ARCH_REG_COUNT = 32;
   typedef logic [5:0] PhysReg;
endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers; the head can be snapshotted and
// restored on mispredict while the tail keeps advancing independently.
module rename_free_list
   import mips_core_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       pop_i,
   input  logic       push_i,
   input  PhysReg     push_data_i,
   input  logic       restore_i,
   input  logic [6:0] restore_head_i,
   output logic [6:0] head_o,
   output PhysReg     head_data_o,
   output logic [6:0] count_o
);
   PhysReg     slots_q [PHYS_REG_COUNT];
   logic [6:0] head_q, head_d;
   logic [6:0] tail_q, tail_d;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (restore_i) begin
         head_d = restore_head_i;
      end else if (pop_i) begin
         head_d = head_q + 7'd1;
      end else begin
         head_d = head_q;
      end
      if (push_i) begin
         tail_d = tail_q + 7'd1;
      end else begin
         tail_d = tail_q;
      end
   end

   // Upper slots start at zero; they are written by frees before ever being popped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHYS_REG_COUNT; i++) begin
            slots_q[i] <= (i < ARCH_REG_COUNT) ? PhysReg'(i + ARCH_REG_COUNT) : 6'd0;
         end
         head_q <= 7'd0;
         tail_q <= 7'd32;
      end else begin
         if (push_i) begin
            slots_q[tail_q[5:0]] <= push_data_i;
         end
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign head_o      = head_q;
   assign head_data_o = slots_q[head_q[5:0]];
   assign count_o     = tail_q - head_q;
endmodule

// File: rtl/rename_table.sv
// Register rename: arch->phys map, physical ready bits, and per-branch
// checkpoints of map and free-list head for mispredict recovery.
module rename_table
   import mips_core_pkg::*;
#(
   parameter int N_PHYS = PHYS_REG_COUNT,
   parameter int N_CKPT = CKPT_COUNT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rename_valid,
   input  logic [4:0]    rs_arch,
   input  logic [4:0]    rt_arch,
   input  logic [4:0]    rw_arch,
   input  logic          uses_rw,
   input  logic          is_cond_branch,
   output PhysReg        rs_phys,
   output PhysReg        rt_phys,
   output PhysReg        rw_phys,
   output PhysReg        rw_phys_old,
   output logic          stall,
   output logic [63:0]   ready_bits,
   input  logic          wb_valid,
   input  PhysReg        wb_phys,
   input  logic          free_valid,
   input  PhysReg        free_phys,
   input  logic          recover,
   input  logic [1:0]    recover_entry,
   input  logic          ckpt_release
);
   PhysReg      map_q [ARCH_REG_COUNT];
   PhysReg      map_d [ARCH_REG_COUNT];
   PhysReg      ckpt_map_q [N_CKPT][ARCH_REG_COUNT];
   logic [6:0]  ckpt_fhead_q [N_CKPT];
   logic [1:0]  ckpt_head_q, ckpt_head_d;
   logic [1:0]  ckpt_tail_q, ckpt_tail_d;
   logic [2:0]  ckpt_count_q, ckpt_count_d;
   logic [63:0] ready_q, ready_d;

   logic        alloc_req_s, do_rename_s, do_alloc_s, take_ckpt_s, release_s, push_s;
   logic [6:0]  fl_head_s, fl_count_s;
   PhysReg      fl_head_data_s;

   rename_free_list u_free_list (
      .clk            (clk),
      .rst            (rst),
      .pop_i          (do_alloc_s),
      .push_i         (push_s),
      .push_data_i    (free_phys),
      .restore_i      (recover),
      .restore_head_i (ckpt_fhead_q[recover_entry]),
      .head_o         (fl_head_s),
      .head_data_o    (fl_head_data_s),
      .count_o        (fl_count_s)
   );

   always_comb begin
      alloc_req_s = uses_rw && (rw_arch != 5'd0);
      stall       = rename_valid && ((alloc_req_s && (fl_count_s == 7'd0)) ||
                                     (is_cond_branch && (ckpt_count_q == 3'(N_CKPT))));
      do_rename_s = rename_valid && !stall && !recover;
      do_alloc_s  = do_rename_s && alloc_req_s;
      take_ckpt_s = do_rename_s && is_cond_branch;
      release_s   = ckpt_release && (ckpt_count_q != 3'd0) && !recover;
      push_s      = free_valid && (free_phys != 6'd0);
      rs_phys     = map_q[rs_arch];
      rt_phys     = map_q[rt_arch];
      rw_phys     = alloc_req_s ? fl_head_data_s : 6'd0;
      rw_phys_old = alloc_req_s ? map_q[rw_arch] : 6'd0;
   end

   // map_d is the post-rename map; it is also what a branch checkpoint captures.
   always_comb begin
      map_d = map_q;
      if (recover) begin
         map_d = ckpt_map_q[recover_entry];
      end else if (do_alloc_s) begin
         map_d[rw_arch] = fl_head_data_s;
      end else begin
         map_d = map_q;
      end
      ready_d = ready_q;
      if (do_alloc_s) begin
         ready_d[fl_head_data_s] = 1'b0;
      end
      if (wb_valid) begin
         ready_d[wb_phys] = 1'b1;
      end
      ready_d[0] = 1'b1;
   end

   always_comb begin
      ckpt_head_d  = ckpt_head_q + {1'b0, release_s};
      ckpt_tail_d  = ckpt_tail_q + {1'b0, take_ckpt_s};
      ckpt_count_d = ckpt_count_q;
      if (recover) begin
         ckpt_tail_d  = recover_entry;
         ckpt_count_d = {1'b0, recover_entry - ckpt_head_q};
      end else begin
         case ({take_ckpt_s, release_s})
            2'b10:   ckpt_count_d = ckpt_count_q + 3'd1;
            2'b01:   ckpt_count_d = ckpt_count_q - 3'd1;
            default: ckpt_count_d = ckpt_count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REG_COUNT; i++) begin
            map_q[i] <= PhysReg'(i);
         end
         for (int c = 0; c < N_CKPT; c++) begin
            for (int i = 0; i < ARCH_REG_COUNT; i++) begin
               ckpt_map_q[c][i] <= PhysReg'(i);
            end
            ckpt_fhead_q[c] <= 7'd0;
         end
         ready_q      <= 64'h0000_0000_FFFF_FFFF;
         ckpt_head_q  <= 2'd0;
         ckpt_tail_q  <= 2'd0;
         ckpt_count_q <= 3'd0;
      end else begin
         map_q <= map_d;
         if (take_ckpt_s) begin
            ckpt_map_q[ckpt_tail_q]   <= map_d;
            ckpt_fhead_q[ckpt_tail_q] <= fl_head_s + {6'd0, do_alloc_s};
         end
         ready_q      <= ready_d;
         ckpt_head_q  <= ckpt_head_d;
         ckpt_tail_q  <= ckpt_tail_d;
         ckpt_count_q <= ckpt_count_d;
      end
   end

   assign ready_bits = ready_q;
endmodule

// File: tb/tb_rename_table.sv
// Directed scoreboard bench for rename_table: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_rename_table;
   import mips_core_pkg::*;

   logic clk = 1'b0, rst = 1'b1;
   logic rename_valid, uses_rw, is_cond_branch, wb_valid, free_valid, recover, ckpt_release;
   logic [4:0] rs_arch, rt_arch, rw_arch;
   logic [1:0] recover_entry;
   PhysReg rs_phys, rt_phys, rw_phys, rw_phys_old, wb_phys, free_phys;
   logic stall;
   logic [63:0] ready_bits;

   typedef struct {int cyc; int kind; int idx; int val; string name;} exp_t;
   exp_t exp_q[$];
   int cyc = 0, n_tests = 0, n_fail = 0;

   rename_table dut (
      .clk(clk), .rst(rst), .rename_valid(rename_valid),
      .rs_arch(rs_arch), .rt_arch(rt_arch), .rw_arch(rw_arch),
      .uses_rw(uses_rw), .is_cond_branch(is_cond_branch),
      .rs_phys(rs_phys), .rt_phys(rt_phys), .rw_phys(rw_phys), .rw_phys_old(rw_phys_old),
      .stall(stall), .ready_bits(ready_bits),
      .wb_valid(wb_valid), .wb_phys(wb_phys), .free_valid(free_valid), .free_phys(free_phys),
      .recover(recover), .recover_entry(recover_entry), .ckpt_release(ckpt_release)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compare every expectation due in the current cycle
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         int act;
         e = exp_q.pop_front();
         case (e.kind)
            0: act = int'(rs_phys);
            1: act = int'(rt_phys);
            2: act = int'(rw_phys);
            3: act = int'(rw_phys_old);
            4: act = int'(stall);
            default: act = int'(ready_bits[e.idx]);
         endcase
         n_tests++;
         if (act != e.val) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, act, e.val);
         end
      end
   end

   task automatic expect_v(input int kind, input int idx, input int val, input string name);
      exp_t e;
      e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      rename_valid = 0; uses_rw = 0; is_cond_branch = 0; wb_valid = 0; free_valid = 0;
      recover = 0; ckpt_release = 0; rs_arch = 0; rt_arch = 0; rw_arch = 0;
      recover_entry = 0; wb_phys = 0; free_phys = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ren(input int rs, input int rt, input int rw, input bit br);
      idle();
      rename_valid = 1; rs_arch = 5'(rs); rt_arch = 5'(rt); rw_arch = 5'(rw);
      uses_rw = 1'(rw != 0); is_cond_branch = br;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      // reset state
      rs_arch = 5; rt_arch = 31;
      expect_v(0, 0, 5, "reset_map5");
      expect_v(1, 0, 31, "reset_map31");
      expect_v(4, 0, 0, "reset_stall");
      expect_v(5, 0, 1, "reset_ready0");
      expect_v(5, 31, 1, "reset_ready31");
      expect_v(5, 32, 0, "reset_ready32");
      tick();
      // add r3,r1,r2
      ren(1, 2, 3, 0);
      expect_v(0, 0, 1, "add_rs"); expect_v(1, 0, 2, "add_rt");
      expect_v(2, 0, 32, "add_rw"); expect_v(3, 0, 3, "add_rw_old");
      tick();
      idle(); rs_arch = 3;
      expect_v(0, 0, 32, "map3_after_add"); expect_v(5, 32, 0, "ready32_cleared");
      tick();
      // branch checkpoint, then r3->33, r4->34, recover entry 0
      ren(0, 0, 0, 1);
      expect_v(4, 0, 0, "br_stall"); expect_v(2, 0, 0, "br_rw_none");
      tick();
      ren(3, 0, 3, 0);
      expect_v(0, 0, 32, "r3_src_old_map"); expect_v(2, 0, 33, "r3_rw33");
      expect_v(3, 0, 32, "r3_old32");
      tick();
      ren(3, 4, 4, 0);
      expect_v(0, 0, 33, "map3_33"); expect_v(2, 0, 34, "r4_rw34"); expect_v(3, 0, 4, "r4_old4");
      tick();
      ren(0, 0, 5, 0); recover = 1; recover_entry = 0;
      tick();
      ren(3, 4, 6, 0);
      expect_v(0, 0, 32, "recov_map3"); expect_v(1, 0, 4, "recov_map4");
      expect_v(2, 0, 33, "recov_next_alloc"); expect_v(3, 0, 6, "recov_r6_old");
      tick();
      // writeback while renaming rw_arch=0
      ren(0, 0, 0, 0); uses_rw = 1; wb_valid = 1; wb_phys = 32;
      expect_v(2, 0, 0, "r0_rw"); expect_v(3, 0, 0, "r0_old"); expect_v(4, 0, 0, "r0_stall");
      tick();
      ren(6, 0, 7, 0);
      expect_v(5, 32, 1, "wb_ready32"); expect_v(0, 0, 33, "map6_33");
      expect_v(2, 0, 34, "r0_no_pop");
      tick();
      // four checkpoints, fifth stalls until a release
      for (int i = 0; i < 4; i++) begin
         ren(0, 0, 0, 1);
         expect_v(4, 0, 0, "ckpt_fill_stall");
         tick();
      end
      ren(0, 0, 0, 1);
      expect_v(4, 0, 1, "ckpt_full_stall");
      tick();
      ren(0, 0, 0, 1); ckpt_release = 1;
      expect_v(4, 0, 1, "ckpt_release_cycle_stall");
      tick();
      ren(0, 0, 0, 1);
      expect_v(4, 0, 0, "ckpt_after_release");
      tick();
      // recover entry 1 with a same-cycle free of 40 and an ignored rename
      ren(0, 0, 8, 0); recover = 1; recover_entry = 1; free_valid = 1; free_phys = 40;
      tick();
      // drain: 29 regs 35..63, then the freed 40, then stall
      for (int i = 0; i < 30; i++) begin
         ren(8, 3, i + 1, 0);
         if (i == 0) begin
            expect_v(0, 0, 8, "recov_ignored_rename");
            expect_v(1, 0, 32, "recov1_map3");
            expect_v(3, 0, 1, "drain_old1");
         end
         expect_v(2, 0, (i < 29) ? 35 + i : 40, "drain_rw");
         expect_v(4, 0, 0, "drain_stall");
         tick();
      end
      ren(0, 0, 9, 0);
      expect_v(4, 0, 1, "empty_stall");
      tick();
      ren(0, 0, 9, 0); free_valid = 1; free_phys = 3;
      expect_v(4, 0, 1, "no_free_bypass");
      tick();
      ren(0, 0, 9, 0);
      expect_v(4, 0, 0, "after_free_stall"); expect_v(2, 0, 3, "after_free_rw3");
      tick();
      idle();
      expect_v(5, 3, 0, "ready3_cleared"); expect_v(5, 1, 1, "ready1_kept");
      tick();
      // reset mid-operation overrides everything
      ren(0, 0, 5, 0); rst = 1; wb_valid = 1; wb_phys = 33; free_valid = 1; free_phys = 7;
      tick();
      rst = 0;
      ren(5, 0, 9, 0);
      expect_v(0, 0, 5, "rst_map5"); expect_v(2, 0, 32, "rst_rw32");
      expect_v(3, 0, 9, "rst_old9"); expect_v(5, 33, 0, "rst_ready33");
      tick();
      idle();
      tick(); tick();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
